// File: rtl/mux_select_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_select_arbiter_if
// Description : Request/grant bundle between requesters and the mux-select
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_select_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] select;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;

    // Requester side
    modport master (
        output req,
        output done,
        input  select,
        input  grant,
        input  grant_valid,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  req,
        input  done,
        output select,
        output grant,
        output grant_valid,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_select_arbiter
// Description : Round-robin arbiter driving the select of a 4:1 mux, with
//               owner release and hold-limit forced release.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_select_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    mux_select_arbiter_if.slave  bus
);

    localparam logic [0:0]       c_IDLE      = 1'b0;
    localparam logic [0:0]       c_BUSY      = 1'b1;
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       r_state;
    logic [1:0]       r_select;
    logic [3:0]       r_grant;
    logic             r_grant_valid;
    logic             r_timeout;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [0:0]       w_state_nxt;
    logic [1:0]       w_select_nxt;
    logic [3:0]       w_grant_nxt;
    logic             w_grant_valid_nxt;
    logic             w_timeout_nxt;
    logic [1:0]       w_last_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;

    logic             w_found;
    logic [1:0]       w_winner;
    logic             w_at_limit;
    logic             w_release;
    logic             w_limit_only;

    // Round-robin search starting just after the last winner
    always_comb begin
        logic [1:0] idx;
        w_found  = 1'b0;
        w_winner = r_last;
        idx      = r_last;
        for (int k = 1; k <= 4; k++) begin
            idx = r_last + 2'(k);
            if (!w_found && bus.req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    assign w_at_limit   = (r_hold_cnt == c_HOLD_LAST);
    assign w_release    = bus.done | ~bus.req[r_select] | w_at_limit;
    // timeout only flags releases the owner did not ask for itself
    assign w_limit_only = w_at_limit & ~bus.done & bus.req[r_select];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_select      <= 2'd0;
            r_grant       <= 4'b0000;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_last        <= 2'd3;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_select      <= w_select_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_timeout     <= w_timeout_nxt;
            r_last        <= w_last_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found)   w_state_nxt = c_BUSY;
            c_BUSY:  if (w_release) w_state_nxt = c_IDLE;
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    // select is held across IDLE so the mux output stays quiet between grants
    always_comb begin
        w_select_nxt      = r_select;
        w_grant_nxt       = 4'b0000;
        w_grant_valid_nxt = 1'b0;
        w_timeout_nxt     = 1'b0;
        w_last_nxt        = r_last;
        w_hold_cnt_nxt    = r_hold_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_select_nxt      = w_winner;
                    w_grant_nxt       = 4'b0001 << w_winner;
                    w_grant_valid_nxt = 1'b1;
                    w_last_nxt        = w_winner;
                    w_hold_cnt_nxt    = '0;
                end
            end
            c_BUSY: begin
                if (w_release) begin
                    w_timeout_nxt  = w_limit_only;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_grant_nxt       = r_grant;
                    w_grant_valid_nxt = 1'b1;
                    w_hold_cnt_nxt    = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.select      = r_select;
    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_select_arbiter
// Description : Directed vector bench for mux_select_arbiter (MAX_HOLD=8 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_select_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       vld;
        logic       tmo;
    } vec_t;

    localparam int c_NVEC = 26;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl [c_NVEC];

    mux_select_arbiter_if bus  ();
    mux_select_arbiter_if bus1 ();

    assign bus1.req  = bus.req;
    assign bus1.done = bus.done;

    mux_select_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mux_select_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic d);
        reset    = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [1:0] sel,
                              input logic [3:0] gnt, input logic vld, input logic tmo);
        chk({name, ".select"},      {6'd0, bus.select},      {6'd0, sel});
        chk({name, ".grant"},       {4'd0, bus.grant},       {4'd0, gnt});
        chk({name, ".grant_valid"}, {7'd0, bus.grant_valid}, {7'd0, vld});
        chk({name, ".timeout"},     {7'd0, bus.timeout},     {7'd0, tmo});
        chk({name, ".valid_eq_grant"}, {7'd0, bus.grant_valid}, {7'd0, (bus.grant != 4'b0000)});
        if (bus.grant_valid)
            chk({name, ".grant_at_select"}, {7'd0, bus.grant[bus.select]}, 8'd1);
    endtask

    task automatic expect_out1(input string name, input logic [1:0] sel,
                               input logic [3:0] gnt, input logic vld, input logic tmo);
        chk({name, ".h1.select"},      {6'd0, bus1.select},      {6'd0, sel});
        chk({name, ".h1.grant"},       {4'd0, bus1.grant},       {4'd0, gnt});
        chk({name, ".h1.grant_valid"}, {7'd0, bus1.grant_valid}, {7'd0, vld});
        chk({name, ".h1.timeout"},     {7'd0, bus1.timeout},     {7'd0, tmo});
    endtask

    initial begin
        // {rst, req, done, sel, grant, valid, timeout}
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        // single requester 2, done on 4th BUSY cycle
        tbl[1]  = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        // reset, then full rotation 0,1,2,3,0 with done on 2nd BUSY cycle
        tbl[6]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        // last=0, req=1001 -> 3 wins; then last=3 -> wrap to 0
        tbl[17] = '{1'b0, 4'b1001, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 4'b1001, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 4'b1001, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 4'b1001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        // grant 1, owner drops request while 3 waits
        tbl[21] = '{1'b0, 4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 4'b1000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
        tbl[25] = '{1'b0, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0};

        bus.req  = 4'b0000;
        bus.done = 1'b0;
        drive(1'b1, 4'b0000, 1'b0);

        for (int i = 0; i < c_NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].done);
            expect_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].vld, tbl[i].tmo);
        end

        // Hold limit: sole requester 1 held 8 cycles, timeout pulse, regrant
        drive(1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 4'b0010, 1'b0);
            expect_out($sformatf("hold%0d", k), 2'd1, 4'b0010, 1'b1, 1'b0);
        end
        drive(1'b0, 4'b0010, 1'b0);
        expect_out("hold_timeout", 2'd1, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0010, 1'b0);
        expect_out("hold_regrant", 2'd1, 4'b0010, 1'b1, 1'b0);

        // done coinciding with the limit suppresses timeout
        drive(1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b0, 4'b0010, 1'b0);
        expect_out("coinc_pre", 2'd1, 4'b0010, 1'b1, 1'b0);
        drive(1'b0, 4'b0010, 1'b1);
        expect_out("coinc_release", 2'd1, 4'b0000, 1'b0, 1'b0);

        // Reset mid-grant on index 2
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b0100, 1'b0);
        expect_out("rst_pre", 2'd2, 4'b0100, 1'b1, 1'b0);
        drive(1'b1, 4'b0100, 1'b0);
        expect_out("rst_mid", 2'd0, 4'b0000, 1'b0, 1'b0);
        drive(1'b0, 4'b1111, 1'b0);
        expect_out("rst_after", 2'd0, 4'b0001, 1'b1, 1'b0);

        // MAX_HOLD=1: every grant one cycle with a timeout pulse
        drive(1'b1, 4'b0000, 1'b0);
        drive(1'b0, 4'b0010, 1'b0);
        expect_out1("mh1_g0", 2'd1, 4'b0010, 1'b1, 1'b0);
        drive(1'b0, 4'b0010, 1'b0);
        expect_out1("mh1_t0", 2'd1, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0110, 1'b0);
        expect_out1("mh1_g1", 2'd2, 4'b0100, 1'b1, 1'b0);
        drive(1'b0, 4'b0110, 1'b1);
        expect_out1("mh1_done", 2'd2, 4'b0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
